dibit_serializer: RTL
=====================

Name: dibit_serializer

Overview:
- Upstream feed stage for the dibit parity accumulator.
- Accepts parallel words over a valid/ready handshake and emits them as a stream of 2-bit symbols, one per accepted transfer, with first/last frame markers.
- Its symbol output connects directly to the accumulator's 2-bit symbol input.
- Supports back-to-back words with no idle cycle and honours downstream backpressure.

Parameters:
- WORD_W, 8, input word width in bits; must be even and >= 4 (elaboration error otherwise).
- MSB_FIRST, 1, 1: first symbol = word[WORD_W-1:WORD_W-2]; 0: first symbol = word[1:0].

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- in_data  input  WORD_W  parallel word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- sym_out  output  2  current symbol.
- sym_valid  output  1  sym_out valid.
- sym_ready  input  1  downstream accepts symbol.
- sym_first  output  1  sym_out is the first symbol of a frame.
- sym_last  output  1  sym_out is the last symbol of a frame.
- busy  output  1  a frame is in flight (state != IDLE).

Behaviour:
- Reset values while rstn is low: state IDLE, sym_valid 0, sym_out 2'b00, sym_first 0, sym_last 0, shift register 0, symbol counter 0.
- NSYM = WORD_W/2 data symbols per frame (+1 with the optional feature).
- States: IDLE, SHIFT (plus PAR with the optional feature).
- Handshakes:
  - Input transfer: in_valid && in_ready on a rising edge.
  - Symbol transfer: sym_valid && sym_ready on a rising edge.
- in_ready (combinational) = (state==IDLE) || (sym_valid && sym_ready && sym_last). This allows zero-bubble back-to-back frames.
- IDLE + input transfer: load the shift register, counter := 0, go to SHIFT. The first symbol is on sym_out with sym_valid=1 and sym_first=1 in the next cycle (latency 1 clock from acceptance).
- SHIFT: sym_out = top dibit of the shift register (or bottom dibit if MSB_FIRST=0).
  - On symbol transfer: shift by 2 and increment the counter.
  - sym_last=1 when counter == NSYM-1 (feature off).
- Last-symbol transfer with a simultaneous input transfer: reload immediately and stay in SHIFT with sym_first=1 next cycle.
- Last-symbol transfer without an input transfer: go to IDLE and drop sym_valid next cycle.
- Backpressure: while sym_valid && !sym_ready, sym_out, sym_first, sym_last and sym_valid are held stable (AXI-style). in_valid is ignored unless in_ready=1.
- Once sym_valid is asserted it is never deasserted before its transfer.
- Reset mid-frame: the frame is discarded, outputs take their reset values immediately (asynchronously), and no partial frame is emitted after release.
- For NSYM==1 cases, sym_first and sym_last may both be 1. This cannot occur with WORD_W>=4 and feature off; it is listed for completeness.

Optional Feature:
- Macro DIBIT_SERIALIZER_PARITY_EN.
- Defined:
  - When the word is loaded, register par = ^in_data.
  - After the last data symbol transfers, enter PAR and emit one extra symbol {1'b0, par} with sym_last=1. Data symbols then carry sym_last=0.
  - in_ready and back-to-back rules apply to the parity symbol, which is now the frame's last symbol.
  - Result: the XOR of all bits of all symbols in a frame is 0, so the downstream accumulator returns to its pre-frame value at every frame end.
- Undefined: the PAR state and the par register are absent, and frames are exactly NSYM symbols.

Decomposition:
- Package dibit_serializer_pkg:
  - state enum (IDLE, SHIFT, PAR).
  - dibit_t (logic [1:0]).
  - function nsym(WORD_W).
  - localparam CNT_W = $clog2(NSYM+1).
- One natural sub-module: dibit_shift_reg.
  - Load/shift-by-2 register with the MSB_FIRST selection.
  - Exposes the current dibit.
- FSM, counter and handshake logic stay in the top level.

Test Plan:
- Feature off, WORD_W=8, MSB_FIRST=1, sym_ready=1, in_data=0xB4 → sym_out 10,11,01,00 on 4 consecutive cycles; sym_first on the first only, sym_last on the fourth only; in_ready=1 during the fourth.
- MSB_FIRST=0, in_data=0xB4 → 00,01,11,10.
- Back-to-back: 0xB4 then 0x01 with in_valid held → 8 contiguous valid symbols with no bubble; the second frame starts 10? no, it starts 00,00,00,01 (MSB first) with sym_first on its first symbol.
- Backpressure: sym_ready low for 3 cycles on the 2nd symbol → sym_out=11 held stable with sym_valid=1, in_ready=0; the stream resumes unchanged.
- Reset asserted after the 2nd symbol of 0xB4 → sym_valid=0 and sym_out=00 immediately; after release, in_ready=1 and no residual symbols appear.
- DIBIT_SERIALIZER_PARITY_EN, 0xB4 → 10,11,01,00,00 with sym_last on the 5th only. 0x01 → 00,00,00,01,01. The bench reference accumulator returns to 0 after each frame.

Source files
------------

// File: rtl/dibit_serializer_pkg.sv
// Shared types and sizing helpers for the dibit serializer.
// Purely declarative: no logic, no latency, no flow control.
package dibit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  typedef logic [1:0] dibit_t;

  function automatic int nsym(input int word_w);
    return word_w / 2;
  endfunction

endpackage

// File: rtl/dibit_shift_reg.sv
// Load/shift-by-2 word register exposing the next dibit to send; load wins over shift.
// Output follows the register with no added latency; shifting is gated by the caller's handshake.
module dibit_shift_reg
  import dibit_serializer_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_shift,
  output dibit_t            o_dibit
);

  logic [WORD_W-1:0] r_sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      if (MSB_FIRST) r_sr <= {r_sr[WORD_W-3:0], 2'b00};
      else           r_sr <= {2'b00, r_sr[WORD_W-1:2]};
    end
  end

  assign o_dibit = MSB_FIRST ? r_sr[WORD_W-1:WORD_W-2] : r_sr[1:0];

endmodule

// File: rtl/dibit_serializer.sv
// Word-to-dibit serializer: first symbol 1 clk after acceptance, zero-bubble frames, AXI-style hold under backpressure.
// DIBIT_SERIALIZER_PARITY_EN appends a {0,parity} symbol so each frame's bits XOR to zero.
module dibit_serializer
  import dibit_serializer_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        sym_out,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              sym_first,
  output logic              sym_last,
  output logic              busy
);

  localparam int NSYM  = nsym(WORD_W);
  localparam int CNT_W = $clog2(NSYM + 1);

  if ((WORD_W % 2) != 0 || WORD_W < 4) begin : g_bad_word_w
    $error("dibit_serializer: WORD_W must be even and >= 4");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  dibit_t            w_dibit;
  logic              w_in_xfer;
  logic              w_sym_xfer;
  logic              w_last_data;
  logic              w_shift;

  assign w_in_xfer   = in_valid && in_ready;
  assign w_sym_xfer  = sym_valid && sym_ready;
  assign w_last_data = (r_cnt == CNT_W'(NSYM - 1));
  assign w_shift     = w_sym_xfer && (r_state == SHIFT);

  dibit_shift_reg #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_in_xfer),
    .i_data  (in_data),
    .i_shift (w_shift),
    .o_dibit (w_dibit)
  );

`ifdef DIBIT_SERIALIZER_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          r_par <= 1'b0;
    else if (w_in_xfer) r_par <= ^in_data;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_xfer)    r_cnt <= '0;
      else if (w_shift) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_in_xfer) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_sym_xfer && w_last_data) begin
`ifdef DIBIT_SERIALIZER_PARITY_EN
          w_state_nxt = PAR;
`else
          w_state_nxt = w_in_xfer ? SHIFT : IDLE;
`endif
        end
      end
      PAR: begin
`ifdef DIBIT_SERIALIZER_PARITY_EN
        if (w_sym_xfer) w_state_nxt = w_in_xfer ? SHIFT : IDLE;
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only, so reset clears them asynchronously.
  always_comb begin
    sym_valid = (r_state != IDLE);
    busy      = (r_state != IDLE);
    sym_out   = 2'b00;
    sym_first = (r_state == SHIFT) && (r_cnt == '0);
`ifdef DIBIT_SERIALIZER_PARITY_EN
    sym_last  = (r_state == PAR);
    if (r_state == PAR) sym_out = {1'b0, r_par};
`else
    sym_last  = (r_state == SHIFT) && w_last_data;
`endif
    if (r_state == SHIFT) sym_out = w_dibit;
    in_ready  = (r_state == IDLE) || (sym_valid && sym_ready && sym_last);
  end

endmodule
